// File: rtl/stopwatch_lap_timer_pkg.sv
// Shared helpers for the stopwatch/lap-timer slice.
package stopwatch_pkg;

    // Width needed to index n channels; never less than one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_channel.sv
// One stopwatch channel: clear > stop > start/running priority, with wrap or
// saturate at MAX on each prescaler tick.
module sw_channel
    import stopwatch_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX        = 99
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  mode_sat,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  running,
    output logic                  wrap_pulse
);

    localparam logic [DATA_WIDTH-1:0] MAX_C = DATA_WIDTH'(MAX);

    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic                  running_q, running_d;
    logic                  wrap_q, wrap_d;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        count_d   = count_q;
        running_d = running_q;
        wrap_d    = 1'b0;
        if (clear) begin
            count_d = '0;
            if (start && !stop) running_d = 1'b1;
        end else if (stop) begin
            running_d = 1'b0;
        end else if (start || running_q) begin
            running_d = 1'b1;
            if (tick) begin
                if (count_q == MAX_C) begin
                    if (!mode_sat) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
        end
    end

    assign count      = count_q;
    assign running    = running_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: rtl/stopwatch_lap_timer.sv
// Multi-channel stopwatch with a shared tick prescaler and a lap-capture FIFO
// drained over valid/ready.
module stopwatch_lap_timer
    import stopwatch_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX        = 99,
    parameter int NUM_CH     = 4,
    parameter int PRESCALE   = 1,
    parameter int LAP_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CH-1:0]                start,
    input  logic [NUM_CH-1:0]                stop,
    input  logic [NUM_CH-1:0]                clear,
    input  logic                             mode_sat,
    input  logic [NUM_CH-1:0]                lap,
    input  logic                             lap_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0]     count,
    output logic [NUM_CH-1:0]                running,
    output logic [NUM_CH-1:0]                wrap_pulse,
    output logic                             lap_valid,
    output logic [DATA_WIDTH-1:0]            lap_data,
    output logic [ch_idx_w(NUM_CH)-1:0]      lap_ch,
    output logic                             lap_overflow
);

    localparam int CH_W = ch_idx_w(NUM_CH);
    localparam int AW   = $clog2(LAP_DEPTH);
    localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef struct packed {
        logic [CH_W-1:0]       ch;
        logic [DATA_WIDTH-1:0] data;
    } lap_entry_t;

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    always_comb begin
        tick    = (presc_q == PW'(PRESCALE - 1));
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    logic [DATA_WIDTH-1:0] ch_count [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sw_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .MAX        (MAX)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .start      (start[i]),
            .stop       (stop[i]),
            .clear      (clear[i]),
            .mode_sat   (mode_sat),
            .count      (ch_count[i]),
            .running    (running[i]),
            .wrap_pulse (wrap_pulse[i])
        );
        assign count[i*DATA_WIDTH +: DATA_WIDTH] = ch_count[i];
    end

    logic             lap_any, lap_multi;
    logic [CH_W-1:0]  sel;
    lap_entry_t       new_entry, head;
    lap_entry_t       mem_q [LAP_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             empty, full, push, pop;
    logic             overflow_q, overflow_d;

    // Lowest asserted lap bit wins; the downward scan lets it overwrite higher ones.
    always_comb begin
        sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (lap[i]) sel = CH_W'(i);
        end
        lap_any   = |lap;
        lap_multi = (lap & (lap - 1'b1)) != '0;
        new_entry = '{ch: sel, data: ch_count[sel]};
        head      = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = !empty && lap_ready;
        push       = lap_any && (!full || pop);
        overflow_d = lap_multi || (lap_any && full && !pop);
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: FIFO storage is not reset; empty-state outputs are masked to zero instead.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= new_entry;
    end

    assign lap_valid    = !empty;
    assign lap_data     = empty ? '0 : head.data;
    assign lap_ch       = empty ? '0 : head.ch;
    assign lap_overflow = overflow_q;

endmodule
